// File: rtl/pcie_8b10b_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pcie_8b10b_pkg
// Purpose : Shared constants and types for the PCIe 8b/10b transmit path.
//           Provides the symbol width, the two K28.5 comma encodings and
//           the serializer state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pcie_8b10b_pkg;

   // Encoded 8b/10b symbol width.
   localparam int SYM_W = 10;

   // K28.5 comma in both running disparities, written with bit 0 = "a".
   localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;
   localparam logic [SYM_W-1:0] K28_5_RDP = 10'h283;

   // Serializer operating state.
   typedef enum logic [0:0] {
      ST_OFF = 1'b0,
      ST_RUN = 1'b1
   } tx_state_e;

   // Bits needed to count 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : tx_piso_serializer_if
// Purpose : Bundles the symbol handshake and serial outputs of the PISO
//           transmitter.
// Signals : tx_en     - serialization enable (sampled at symbol boundaries)
//           din       - encoded symbol
//           din_valid - din holds a symbol
//           din_ready - transmitter can accept a symbol
//           sout      - serial data, LSB first
//           sym_start - sout carries bit 0 of a symbol
//           underrun  - current symbol is idle filler
// Modports: master - symbol source / serial sink
//           slave  - the serializer
// Revision: 1.0 - initial release
// ============================================================================
interface tx_piso_serializer_if
   import pcie_8b10b_pkg::*;
#(
   parameter int SYM_W = pcie_8b10b_pkg::SYM_W
);

   logic             tx_en;
   logic [SYM_W-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sym_start;
   logic             underrun;

   modport master (
      output tx_en,
      output din,
      output din_valid,
      input  din_ready,
      input  sout,
      input  sym_start,
      input  underrun
   );

   modport slave (
      input  tx_en,
      input  din,
      input  din_valid,
      output din_ready,
      output sout,
      output sym_start,
      output underrun
   );

endinterface
`default_nettype wire

// File: rtl/tx_hold_reg.sv
`default_nettype none
// ============================================================================
// Module  : tx_hold_reg
// Purpose : Single-entry valid/ready holding register in front of the
//           shift register. A word is captured when din_valid_i and
//           din_ready_o are both high at a rising edge; pop_i empties it.
// Ports   : clk         - clock
//           rst         - asynchronous active-low reset
//           din_i       - incoming symbol
//           din_valid_i - din_i is valid
//           din_ready_o - register is empty (registered)
//           pop_i       - consumer takes the held word this cycle
//           hold_o      - held symbol
//           hold_full_o - hold_o is valid
// Revision: 1.0 - initial release
// ============================================================================
module tx_hold_reg
   import pcie_8b10b_pkg::*;
#(
   parameter int SYM_W = pcie_8b10b_pkg::SYM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] din_i,
   input  logic             din_valid_i,
   output logic             din_ready_o,
   input  logic             pop_i,
   output logic [SYM_W-1:0] hold_o,
   output logic             hold_full_o
);

   logic [SYM_W-1:0] hold_q;
   logic [SYM_W-1:0] hold_d;
   logic             full_q;
   logic             full_d;
   logic             ready_q;
   logic             ready_d;
   logic             w_accept;

   // Accept and pop are mutually exclusive: accept needs the register
   // empty, pop is only issued while it is full.
   always_comb begin
      w_accept = din_valid_i && ready_q;
      hold_d   = hold_q;
      full_d   = full_q;
      if (w_accept) begin
         hold_d = din_i;
         full_d = 1'b1;
      end else if (pop_i) begin
         full_d = 1'b0;
      end
      // Ready is kept in its own flop so din_ready_o has no
      // combinational path from any input.
      ready_d = !full_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q  <= '0;
         full_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         hold_q  <= hold_d;
         full_q  <= full_d;
         ready_q <= ready_d;
      end
   end

   assign din_ready_o = ready_q;
   assign hold_o      = hold_q;
   assign hold_full_o = full_q;

endmodule
`default_nettype wire

// File: rtl/tx_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tx_piso_serializer
// Purpose : 10-bit parallel-in/serial-out transmitter for the 8b/10b path.
//           Symbols are shifted out LSB first, back to back, one bit per
//           clock. When no symbol is waiting at a boundary the IDLE_SYM
//           filler is sent and flagged as an underrun.
// Ports   : clk - clock (rising edge)
//           rst - asynchronous active-low reset
//           bus - tx_piso_serializer_if.slave (tx_en, din, din_valid,
//                 din_ready, sout, sym_start, underrun)
// Revision: 1.0 - initial release
// ============================================================================
module tx_piso_serializer
   import pcie_8b10b_pkg::*;
#(
   parameter int               SYM_W    = pcie_8b10b_pkg::SYM_W,
   parameter logic [SYM_W-1:0] IDLE_SYM = K28_5_RDN
) (
   input  logic                 clk,
   input  logic                 rst,
   tx_piso_serializer_if.slave  bus
);

   localparam int                c_CNT_W    = cnt_width(SYM_W);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SYM_W - 1);

   tx_state_e          state_q;
   tx_state_e          state_d;
   logic [c_CNT_W-1:0] cnt_q;
   logic [c_CNT_W-1:0] cnt_d;
   logic [SYM_W-1:0]   sh_q;
   logic [SYM_W-1:0]   sh_d;
   logic               idle_q;
   logic               idle_d;
   logic               sym_start_q;
   logic               sym_start_d;

   logic               w_at_last;
   logic               w_load;
   logic               w_pop;
   logic [SYM_W-1:0]   w_hold;
   logic               w_hold_full;
   logic               w_din_ready;

   // ------------------------------------------------------------------
   // Holding register
   // ------------------------------------------------------------------
   tx_hold_reg #(
      .SYM_W (SYM_W)
   ) u_hold (
      .clk         (clk),
      .rst         (rst),
      .din_i       (bus.din),
      .din_valid_i (bus.din_valid),
      .din_ready_o (w_din_ready),
      .pop_i       (w_pop),
      .hold_o      (w_hold),
      .hold_full_o (w_hold_full)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_OFF;
         cnt_q       <= '0;
         sh_q        <= '0;
         idle_q      <= 1'b0;
         sym_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         idle_q      <= idle_d;
         sym_start_q <= sym_start_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_at_last   = (cnt_q == c_CNT_LAST);
      // tx_en only matters at a symbol boundary: from OFF, or on the
      // last bit of the symbol in flight.
      w_load      = bus.tx_en && ((state_q == ST_OFF) || w_at_last);
      // The load samples hold_full as it was before the edge, so a word
      // accepted on the same edge waits for the next boundary.
      w_pop       = w_load && w_hold_full;

      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      idle_d      = idle_q;
      sym_start_d = 1'b0;

      case (state_q)
         ST_OFF: begin
            // Idle line: sh stays zero, nothing shifts.
         end
         ST_RUN: begin
            if (!w_at_last) begin
               sh_d  = {1'b0, sh_q[SYM_W-1:1]};
               cnt_d = cnt_q + c_CNT_W'(1);
            end else if (!bus.tx_en) begin
               // Symbol finished and transmission disabled: park.
               sh_d    = '0;
               cnt_d   = '0;
               idle_d  = 1'b0;
               state_d = ST_OFF;
            end
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase

      if (w_load) begin
         sh_d        = w_hold_full ? w_hold : IDLE_SYM;
         idle_d      = !w_hold_full;
         cnt_d       = '0;
         state_d     = ST_RUN;
         sym_start_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs (all sourced from flops)
   // ------------------------------------------------------------------
   always_comb begin
      bus.sout      = sh_q[0];
      bus.sym_start = sym_start_q;
      bus.underrun  = sym_start_q && idle_q;
      bus.din_ready = w_din_ready;
   end

endmodule
`default_nettype wire
